// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ load/store FUs.
// Optional macro DMEM_ARB_STORE_PRIO_EN: store requesters win over loads in IDLE.
package dmem_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        BUS_COMMAND      command;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
    } FU_MEM_PACKET;

endpackage

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                 NUM_REQ    = 4,
    parameter logic [NUM_REQ-1:0] STORE_MASK = NUM_REQ'(4'b0011)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  mem_req,
    input  FU_MEM_PACKET        req_packet [NUM_REQ],
    output logic [NUM_REQ-1:0]  mem_ack,
    output logic [XLEN-1:0]     rd_data,
    output BUS_COMMAND          proc2Dmem_command,
    output logic [XLEN-1:0]     proc2Dmem_addr,
    output logic [XLEN-1:0]     proc2Dmem_data,
    output MEM_SIZE             proc2Dmem_size,
    input  logic [XLEN-1:0]     Dmem2proc_data,
    input  logic                Dmem2proc_valid,
    output logic                busy
);

    localparam int IW = $clog2(NUM_REQ);

`ifdef DMEM_ARB_STORE_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'h0,
        ISSUE = 2'h1,
        WAIT  = 2'h2,
        ACK   = 2'h3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     grant;
    logic [IW-1:0]     win;
    logic [NUM_REQ-1:0] pool;
    logic [NUM_REQ-1:0] store_req;
    FU_MEM_PACKET      pkt_q;
    logic [XLEN-1:0]   data_q;
    int                j;

    assign store_req = mem_req & STORE_MASK;

    // Pick the first eligible requester scanning upward from rr_ptr.
    always_comb begin
        pool = mem_req;
        if (PRIO_EN && (|store_req)) begin
            pool = store_req;
        end
        win = '0;
        j   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i = i - 1) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (pool[IW'(j)]) begin
                win = IW'(j);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt         = state;
        mem_ack           = '0;
        proc2Dmem_command = BUS_NONE;
        busy              = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (|mem_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                proc2Dmem_command = pkt_q.command;
                state_nxt         = WAIT;
            end
            WAIT: begin
                if (Dmem2proc_valid) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                mem_ack[grant] = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner at grant, memory data on completion, advance rr_ptr on ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            grant  <= '0;
            pkt_q  <= '0;
            data_q <= '0;
        end else begin
            if ((state == IDLE) && (|mem_req)) begin
                grant <= win;
                pkt_q <= req_packet[win];
            end
            if ((state == WAIT) && Dmem2proc_valid) begin
                data_q <= Dmem2proc_data;
            end
            if (state == ACK) begin
                rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign rd_data        = data_q;
    assign proc2Dmem_addr = pkt_q.addr;
    assign proc2Dmem_data = pkt_q.data;
    assign proc2Dmem_size = pkt_q.size;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int N = 4;
    localparam logic [N-1:0] SMASK = 4'b0011;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    mem_req;
    FU_MEM_PACKET    pkt [N];
    logic [N-1:0]    mem_ack;
    logic [31:0]     rd_data;
    BUS_COMMAND      cmd;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    MEM_SIZE         size;
    logic [31:0]     mdata;
    logic            mvalid;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int ptr      = 0;

    dmem_arbiter #(.NUM_REQ(N), .STORE_MASK(SMASK)) dut (
        .clock             (clk),
        .reset             (rst_n),
        .mem_req           (mem_req),
        .req_packet        (pkt),
        .mem_ack           (mem_ack),
        .rd_data           (rd_data),
        .proc2Dmem_command (cmd),
        .proc2Dmem_addr    (addr),
        .proc2Dmem_data    (wdata),
        .proc2Dmem_size    (size),
        .Dmem2proc_data    (mdata),
        .Dmem2proc_valid   (mvalid),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
        end
    endtask

    // Reference winner: lowest rotational distance from ptr among requesters,
    // restricted to stores when store priority is compiled in and any store asks.
    function automatic int model_win(input logic [N-1:0] r);
        logic [N-1:0] p;
        int idx;
        p = r;
`ifdef DMEM_ARB_STORE_PRIO_EN
        if ((r & SMASK) != 0) p = r & SMASK;
`endif
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic FU_MEM_PACKET rand_pkt();
        FU_MEM_PACKET q;
        q.command = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
        q.addr    = $urandom;
        q.data    = $urandom;
        q.size    = MEM_SIZE'($urandom_range(0, 3));
        return q;
    endfunction

    task automatic scramble();
        for (int i = 0; i < N; i++) pkt[i] = rand_pkt();
    endtask

    // Runs one transaction starting from a negedge in IDLE with mem_req set.
    task automatic txn(input int lat, input bit drop, input bit clr,
                       input logic [31:0] d);
        int w;
        FU_MEM_PACKET e;
        w = model_win(mem_req);
        chk("idle_busy", 64'(busy), 64'(0));
        if (w < 0) begin
            chk("no_request", 64'(mem_req), 64'(1));
            return;
        end
        e = pkt[w];
        @(posedge clk); @(negedge clk);
        chk("issue_cmd", 64'(cmd), 64'(e.command));
        chk("issue_addr", 64'(addr), 64'(e.addr));
        chk("issue_data", 64'(wdata), 64'(e.data));
        chk("issue_size", 64'(size), 64'(e.size));
        chk("issue_busy", 64'(busy), 64'(1));
        scramble();
        mvalid = $urandom_range(0, 1);
        mdata  = $urandom;
        @(posedge clk); @(negedge clk);
        mvalid = 1'b0;
        if (drop) mem_req[w] = 1'b0;
        for (int c = 0; c < lat; c++) begin
            chk("wait_cmd", 64'(cmd), 64'(BUS_NONE));
            chk("wait_busy", 64'(busy), 64'(1));
            chk("wait_ack", 64'(mem_ack), 64'(0));
            @(posedge clk); @(negedge clk);
        end
        chk("wait_cmd", 64'(cmd), 64'(BUS_NONE));
        mvalid = 1'b1;
        mdata  = d;
        @(posedge clk); @(negedge clk);
        mvalid = 1'b0;
        mdata  = $urandom;
        chk("ack_onehot", 64'(mem_ack), 64'(1) << w);
        chk("ack_rdata", 64'(rd_data), 64'(d));
        chk("ack_cmd", 64'(cmd), 64'(BUS_NONE));
        ptr = (w + 1) % N;
        if (clr) mem_req[w] = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_ack", 64'(mem_ack), 64'(0));
        chk("rdata_hold", 64'(rd_data), 64'(d));
    endtask

    initial begin
        rst_n   = 1'b0;
        mem_req = '0;
        mvalid  = 1'b0;
        mdata   = '0;
        scramble();
        #3;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ack", 64'(mem_ack), 64'(0));
        chk("rst_cmd", 64'(cmd), 64'(BUS_NONE));
        chk("rst_addr", 64'(addr), 64'(0));
        chk("rst_data", 64'(wdata), 64'(0));
        chk("rst_size", 64'(size), 64'(BYTE));
        chk("rst_rdata", 64'(rd_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single load from requester 2.
        pkt[2].command = BUS_LOAD;
        pkt[2].addr    = 32'h100;
        pkt[2].size    = WORD;
        mem_req        = 4'b0100;
        txn(0, 1'b0, 1'b1, 32'hDEADBEEF);

        // Asynchronous reset while waiting on memory.
        mem_req = 4'b0001;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_ack", 64'(mem_ack), 64'(0));
        chk("arst_cmd", 64'(cmd), 64'(BUS_NONE));
        chk("arst_rdata", 64'(rd_data), 64'(0));
        mem_req = '0;
        mvalid  = 1'b1;
        @(negedge clk);
        mvalid = 1'b0;
        rst_n  = 1'b1;
        ptr    = 0;
        @(negedge clk);
        chk("arst_no_ack", 64'(mem_ack), 64'(0));

        // Fairness with every requester held high.
        mem_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            chk("fair_order", 64'(model_win(mem_req)), 64'(t % N));
            txn(0, 1'b0, 1'b0, $urandom);
        end
        mem_req = '0;

        // Memory response stretched by 10 cycles.
        scramble();
        mem_req = 4'b0010;
        txn(10, 1'b0, 1'b1, $urandom);

        // Requester 1 drops its request while waiting.
        scramble();
        mem_req = 4'b0010;
        txn(2, 1'b1, 1'b1, $urandom);
        chk("drop_ptr", 64'(ptr), 64'(2));
        mem_req = 4'b1011;
        chk("drop_next", 64'(model_win(mem_req)), 64'(3));
        txn(0, 1'b0, 1'b1, $urandom);
        mem_req = '0;

`ifdef DMEM_ARB_STORE_PRIO_EN
        // Stores ahead of loads from rr_ptr=2.
        scramble();
        mem_req = 4'b0010;
        txn(0, 1'b0, 1'b1, $urandom);
        mem_req = 4'b1101;
        chk("prio_first", 64'(model_win(mem_req)), 64'(0));
        txn(0, 1'b0, 1'b1, $urandom);
        chk("prio_second", 64'(model_win(mem_req)), 64'(2));
        txn(0, 1'b0, 1'b1, $urandom);
        chk("prio_third", 64'(model_win(mem_req)), 64'(3));
        txn(0, 1'b0, 1'b1, $urandom);
        mem_req = '0;
`endif

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            scramble();
            mem_req = 4'($urandom_range(1, 15));
            txn($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1,
                $urandom);
            mem_req = '0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
